// File: rtl/riscv_pkg.sv
// Shared types for the front-end redirect controller.
// Also provides the default redirect PC width (ADDR_WIDTH) when the build does not set one.
// Optional statistics are enabled by defining REDIRECT_STATS_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package riscv_pkg;

  // Each value is also the priority class: a larger value wins.
  typedef enum logic [1:0] {
    SRC_DEC  = 2'd0,
    SRC_EX1  = 2'd1,
    SRC_EX0  = 2'd2,
    SRC_TRAP = 2'd3
  } redirect_src_e;

  // "No source" has the same encoding as decode; it is only meaningful with redirect_valid=0.
  localparam redirect_src_e SRC_NONE = SRC_DEC;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_HOLD,
    FR_ISSUE,
    FR_BUBBLE
  } fr_state_e;

  localparam int STAT_W = 32;

  // Increment that stops at all-ones.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/redirect_prio_sel.sv
// Combinational 4-way priority select of redirect requests.
// The order is TRAP > EX0 > EX1 > DEC. The output is {valid, class, pc} of the winner.
module redirect_prio_sel
  import riscv_pkg::*;
#(
  parameter int ADDR_W = `ADDR_WIDTH
) (
  input  logic              trap_valid,
  input  logic [ADDR_W-1:0] trap_pc,
  input  logic [1:0]        ex_valid,
  input  logic [ADDR_W-1:0] ex_pc [2],
  input  logic              dec_valid,
  input  logic [ADDR_W-1:0] dec_pc,
  output logic              sel_valid,
  output redirect_src_e     sel_class,
  output logic [ADDR_W-1:0] sel_pc
);

  // Pick the highest-class request that is valid.
  always_comb begin
    sel_valid = 1'b1;
    sel_class = SRC_DEC;
    sel_pc    = dec_pc;
    if (trap_valid) begin
      sel_class = SRC_TRAP;
      sel_pc    = trap_pc;
    end else if (ex_valid[0]) begin
      sel_class = SRC_EX0;
      sel_pc    = ex_pc[0];
    end else if (ex_valid[1]) begin
      sel_class = SRC_EX1;
      sel_pc    = ex_pc[1];
    end else if (!dec_valid) begin
      sel_valid = 1'b0;
      sel_pc    = '0;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Front-end redirect controller.
// It arbitrates trap, branch-unit and decode redirects and holds the winner while fetch
// stalls. It issues a one-cycle redirect pulse, then flushes the front end and bumps the
// fetch epoch.
// Defining REDIRECT_STATS_EN adds per-class issue counters and a HOLD-cycle counter.
module fetch_redirect_ctrl
  import riscv_pkg::*;
#(
  parameter int ADDR_W        = `ADDR_WIDTH,
  parameter int BUBBLE_CYCLES = 1,
  parameter int EPOCH_W       = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_stall,
  input  logic               trap_valid,
  input  logic [ADDR_W-1:0]  trap_pc,
  input  logic [1:0]         ex_valid,
  input  logic [ADDR_W-1:0]  ex_pc [2],
  input  logic               dec_valid,
  input  logic [ADDR_W-1:0]  dec_pc,
  output logic               redirect_valid,
  output logic [ADDR_W-1:0]  redirect_pc,
  output redirect_src_e      redirect_src,
  output logic               front_flush,
  output logic [EPOCH_W-1:0] epoch
`ifdef REDIRECT_STATS_EN
  ,
  output logic [31:0]        stat_cnt [4],
  output logic [31:0]        stall_hold_cnt
`endif
);

  fr_state_e          state_reg, state_next;
  logic               pend_valid_reg;
  redirect_src_e      pend_class_reg;
  logic [ADDR_W-1:0]  pend_pc_reg;
  logic [2:0]         bubble_cnt_reg, bubble_cnt_next;

  logic               dec_allowed;
  logic               sel_valid;
  redirect_src_e      sel_class;
  logic [ADDR_W-1:0]  sel_pc;

  logic               take_new;
  logic               cand_valid;
  redirect_src_e      cand_class;
  logic [ADDR_W-1:0]  cand_pc;
  logic               issue_next;

  logic               redirect_valid_next;
  logic               front_flush_next;
  logic [ADDR_W-1:0]  redirect_pc_next;
  redirect_src_e      redirect_src_next;
  logic [EPOCH_W-1:0] epoch_next;

  // Decode redirects right behind an issued redirect come from the wrong path.
  assign dec_allowed = (state_reg == FR_IDLE) || (state_reg == FR_HOLD);

  redirect_prio_sel #(.ADDR_W(ADDR_W)) u_prio_sel (
    .trap_valid (trap_valid),
    .trap_pc    (trap_pc),
    .ex_valid   (ex_valid),
    .ex_pc      (ex_pc),
    .dec_valid  (dec_valid & dec_allowed),
    .dec_pc     (dec_pc),
    .sel_valid  (sel_valid),
    .sel_class  (sel_class),
    .sel_pc     (sel_pc)
  );

  // State register plus pending-request and bubble-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= FR_IDLE;
      pend_valid_reg <= 1'b0;
      pend_class_reg <= SRC_NONE;
      pend_pc_reg    <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      bubble_cnt_reg <= bubble_cnt_next;
      if (state_next == FR_HOLD) begin
        pend_valid_reg <= 1'b1;
        pend_class_reg <= cand_class;
        pend_pc_reg    <= cand_pc;
      end else begin
        pend_valid_reg <= 1'b0;
        pend_class_reg <= SRC_NONE;
      end
    end
  end

  // Next state: merge the incoming winner with any pending request, then route it.
  always_comb begin
    state_next      = state_reg;
    bubble_cnt_next = bubble_cnt_reg;
    take_new        = 1'b0;
    // A new request is kept only if it is strictly above the pending class,
    // or above the class just issued.
    unique case (state_reg)
      FR_IDLE: take_new = sel_valid;
      FR_HOLD: take_new = sel_valid && (sel_class > pend_class_reg);
      default: take_new = sel_valid && (sel_class > redirect_src);
    endcase
    cand_valid = take_new || pend_valid_reg;
    cand_class = take_new ? sel_class : pend_class_reg;
    cand_pc    = take_new ? sel_pc    : pend_pc_reg;

    unique case (state_reg)
      FR_IDLE: begin
        if (cand_valid) state_next = fetch_stall ? FR_HOLD : FR_ISSUE;
      end
      FR_HOLD: begin
        if (!fetch_stall) state_next = FR_ISSUE;
      end
      FR_ISSUE: begin
        if (take_new) begin
          state_next = fetch_stall ? FR_HOLD : FR_ISSUE;
        end else if (BUBBLE_CYCLES == 0) begin
          state_next = FR_IDLE;
        end else begin
          state_next      = FR_BUBBLE;
          bubble_cnt_next = 3'(BUBBLE_CYCLES);
        end
      end
      default: begin
        if (take_new) begin
          state_next = fetch_stall ? FR_HOLD : FR_ISSUE;
        end else if (bubble_cnt_reg <= 3'd1) begin
          state_next = FR_IDLE;
        end else begin
          bubble_cnt_next = bubble_cnt_reg - 3'd1;
        end
      end
    endcase
    issue_next = (state_next == FR_ISSUE);
  end

  // Next values for the registered outputs.
  always_comb begin
    redirect_valid_next = issue_next;
    front_flush_next    = (state_next == FR_ISSUE) || (state_next == FR_BUBBLE);
    redirect_pc_next    = issue_next ? cand_pc : redirect_pc;
    redirect_src_next   = issue_next ? cand_class : redirect_src;
    epoch_next          = issue_next ? epoch + 1'b1 : epoch;
  end

  // Output registers; redirect_src also serves as the floor class during ISSUE/BUBBLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      front_flush    <= 1'b0;
      redirect_pc    <= '0;
      redirect_src   <= SRC_NONE;
      epoch          <= '0;
    end else begin
      redirect_valid <= redirect_valid_next;
      front_flush    <= front_flush_next;
      redirect_pc    <= redirect_pc_next;
      redirect_src   <= redirect_src_next;
      epoch          <= epoch_next;
    end
  end

`ifdef REDIRECT_STATS_EN
  for (genvar gi = 0; gi < 4; gi++) begin : g_stat
    // Count issued redirects of class gi.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stat_cnt[gi] <= '0;
      end else if (issue_next && (cand_class == 2'(gi))) begin
        stat_cnt[gi] <= sat_inc(stat_cnt[gi]);
      end
    end
  end

  // Count cycles spent holding a redirect behind a fetch stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_hold_cnt <= '0;
    end else if (state_reg == FR_HOLD) begin
      stall_hold_cnt <= sat_inc(stall_hold_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed self-checking bench for fetch_redirect_ctrl.
// Expected redirects are queued as the stimulus is driven and are popped when redirect_valid
// pulses. Define REDIRECT_STATS_EN to also exercise the statistics counters.
module tb_fetch_redirect_ctrl;
  import riscv_pkg::*;

  localparam int AW = 32;
  localparam int EW = 3;

  typedef struct {
    logic [AW-1:0] pc;
    logic [1:0]    src;
    logic [EW-1:0] ep;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fetch_stall = 1'b0;
  logic          trap_valid = 1'b0;
  logic [AW-1:0] trap_pc = '0;
  logic [1:0]    ex_valid = '0;
  logic [AW-1:0] ex_pc [2];
  logic          dec_valid = 1'b0;
  logic [AW-1:0] dec_pc = '0;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  redirect_src_e redirect_src;
  logic          front_flush;
  logic [EW-1:0] epoch;
`ifdef REDIRECT_STATS_EN
  logic [31:0]   stat_cnt [4];
  logic [31:0]   stall_hold_cnt;
`endif

  int            checks = 0;
  int            errors = 0;
  exp_t          sb[$];
  logic [EW-1:0] exp_epoch = '0;

  fetch_redirect_ctrl #(.ADDR_W(AW), .BUBBLE_CYCLES(1), .EPOCH_W(EW)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_stall    (fetch_stall),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .dec_valid      (dec_valid),
    .dec_pc         (dec_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_src   (redirect_src),
    .front_flush    (front_flush),
    .epoch          (epoch)
`ifdef REDIRECT_STATS_EN
    ,
    .stat_cnt       (stat_cnt),
    .stall_hold_cnt (stall_hold_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_redirect(input logic [AW-1:0] pc, input logic [1:0] src);
    exp_t e;
    exp_epoch = exp_epoch + 1'b1;
    e.pc  = pc;
    e.src = src;
    e.ep  = exp_epoch;
    sb.push_back(e);
  endtask

  // Advance one clock and score any redirect pulse seen 1ns after the edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (redirect_valid === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_redirect: observed pc=0x%0h src=%0d expected no redirect",
               redirect_pc, redirect_src);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        $display("tb: redirect pc=0x%0h src=%0d epoch=%0d (exp pc=0x%0h src=%0d epoch=%0d)",
                 redirect_pc, redirect_src, epoch, e.pc, e.src, e.ep);
        chk("redirect_pc", redirect_pc, e.pc);
        chk("redirect_src", 32'(redirect_src), 32'(e.src));
        chk("redirect_epoch", 32'(epoch), 32'(e.ep));
      end
    end
  endtask

  task automatic clear_req();
    trap_valid = 1'b0;
    ex_valid   = 2'b00;
    dec_valid  = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("reset_valid", 32'(redirect_valid), 0);
    chk("reset_flush", 32'(front_flush), 0);
    chk("reset_epoch", 32'(epoch), 0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    exp_epoch = '0;
  endtask

  initial begin
    ex_pc[0] = '0;
    ex_pc[1] = '0;
    #1;
    // Values after the initial reset.
    chk("init_valid", 32'(redirect_valid), 0);
    chk("init_pc", redirect_pc, 0);
    chk("init_src", 32'(redirect_src), 32'(SRC_NONE));
    chk("init_flush", 32'(front_flush), 0);
    chk("init_epoch", 32'(epoch), 0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // 1: single EX0 redirect, two flush cycles.
    ex_valid[0] = 1'b1; ex_pc[0] = 32'h100;
    expect_redirect(32'h100, SRC_EX0);
    step();
    clear_req();
    chk("t1_valid", 32'(redirect_valid), 1);
    chk("t1_flush_issue", 32'(front_flush), 1);
    chk("t1_epoch", 32'(epoch), 1);
    step();
    chk("t1_flush_bubble", 32'(front_flush), 1);
    chk("t1_valid_bubble", 32'(redirect_valid), 0);
    step();
    chk("t1_flush_idle", 32'(front_flush), 0);
    chk("t1_sb_empty", sb.size(), 0);

    // 2: simultaneous dec/ex1/trap -> trap wins.
    dec_valid = 1'b1; dec_pc = 32'h40;
    ex_valid[1] = 1'b1; ex_pc[1] = 32'h80;
    trap_valid = 1'b1; trap_pc = 32'h1C0;
    expect_redirect(32'h1C0, SRC_TRAP);
    step();
    clear_req();
    step();
    step();
    chk("t2_sb_empty", sb.size(), 0);

    // 3: stalled HOLD with replacement by ex0 and a dropped later dec.
    fetch_stall = 1'b1;
    dec_valid = 1'b1; dec_pc = 32'h40;
    step();
    clear_req();
    chk("t3_hold_valid", 32'(redirect_valid), 0);
    chk("t3_hold_flush", 32'(front_flush), 0);
    step();
    ex_valid[0] = 1'b1; ex_pc[0] = 32'h200;
    step();
    clear_req();
    dec_valid = 1'b1; dec_pc = 32'h44;
    step();
    clear_req();
    step();
    fetch_stall = 1'b0;
    expect_redirect(32'h200, SRC_EX0);
    step();
    chk("t3_issue_flush", 32'(front_flush), 1);
    step();
    step();
    step();
    chk("t3_sb_empty", sb.size(), 0);

    // 4: dec ignored in bubble; a higher trap preempts an EX1 issue.
    ex_valid[1] = 1'b1; ex_pc[1] = 32'h80;
    expect_redirect(32'h80, SRC_EX1);
    step();
    clear_req();
    dec_valid = 1'b1; dec_pc = 32'h60;
    step();
    clear_req();
    chk("t4_bubble_flush", 32'(front_flush), 1);
    trap_valid = 1'b1; trap_pc = 32'h300;
    expect_redirect(32'h300, SRC_TRAP);
    step();
    clear_req();
    ex_valid[0] = 1'b1; ex_pc[0] = 32'h500;
    step();
    clear_req();
    step();
    step();
    chk("t4_epoch", 32'(epoch), 32'(exp_epoch));
    chk("t4_flush_idle", 32'(front_flush), 0);
    chk("t4_sb_empty", sb.size(), 0);

    // 5: nine back-to-back redirects wrap the epoch; then a reset during HOLD.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      dec_valid = 1'b1; dec_pc = 32'h1000 + 32'(i * 4);
      expect_redirect(dec_pc, SRC_DEC);
      step();
      clear_req();
      step();
      step();
    end
    chk("t5_epoch_wrap", 32'(epoch), 1);
    chk("t5_sb_empty", sb.size(), 0);
    fetch_stall = 1'b1;
    dec_valid = 1'b1; dec_pc = 32'h40;
    step();
    clear_req();
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_epoch", 32'(epoch), 0);
    chk("t5_rst_valid", 32'(redirect_valid), 0);
    chk("t5_rst_flush", 32'(front_flush), 0);
    @(negedge clk);
    reset = 1'b0;
    fetch_stall = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t5_post_epoch", 32'(epoch), 0);
    chk("t5_post_flush", 32'(front_flush), 0);

`ifdef REDIRECT_STATS_EN
    // 6: statistics after a trap then an ex0 redirect.
    do_reset();
    dec_valid = 1'b1; dec_pc = 32'h40;
    ex_valid[1] = 1'b1; ex_pc[1] = 32'h80;
    trap_valid = 1'b1; trap_pc = 32'h1C0;
    expect_redirect(32'h1C0, SRC_TRAP);
    step();
    clear_req();
    step();
    step();
    ex_valid[0] = 1'b1; ex_pc[0] = 32'h100;
    expect_redirect(32'h100, SRC_EX0);
    step();
    clear_req();
    step();
    step();
    chk("t6_stat_trap", stat_cnt[3], 1);
    chk("t6_stat_ex0", stat_cnt[2], 1);
    chk("t6_stat_ex1", stat_cnt[1], 0);
    chk("t6_stat_dec", stat_cnt[0], 0);
    chk("t6_stall_hold", stall_hold_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
